// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit.
// Contents: address/instruction widths, opcode field position, the HALT and NOP encodings,
// and the two-state fetch FSM encoding.
package instruction_fetch_unit_pkg;

   localparam int unsigned ADDR_W     = 16;
   localparam int unsigned INSTR_W    = 32;
   localparam int unsigned OPCODE_MSB = 31;
   localparam int unsigned OPCODE_LSB = 29;

   localparam logic [2:0]         OPCODE_HALT = 3'b111;
   localparam logic [INSTR_W-1:0] HALT_WORD   = 32'hE000_0000;
   localparam logic [INSTR_W-1:0] NOP_WORD    = 32'h0000_0000;

   typedef enum logic {
      StRun    = 1'b0,
      StHalted = 1'b1
   } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, drives the combinational instruction memory and captures the
// returned word into the IF/ID register. Handles decode stalls, downstream redirects and HALT.
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   inst_address      word address to instruction memory (the PC register itself)
//   inst_data         instruction word returned for inst_address in the same cycle
//   stall             hold PC and IF/ID contents
//   redirect          taken branch/jump; redirect_pc is the new fetch address
//   if_id_instr       registered instruction for decode
//   if_id_pc          registered address of if_id_instr
//   if_id_valid       if_id_instr is a real instruction
//   halted            fetch is stopped after a HALT word
//   fetch_count       instructions delivered to IF/ID, wrapping
module instruction_fetch_unit #(
   parameter logic [15:0] RESET_PC  = 16'h0000,
   parameter logic [31:0] HALT_WORD = instruction_fetch_unit_pkg::HALT_WORD,
   parameter logic [31:0] NOP_WORD  = instruction_fetch_unit_pkg::NOP_WORD
) (
   input  logic        clk,
   input  logic        rst,
   output logic [15:0] inst_address,
   input  logic [31:0] inst_data,
   input  logic        stall,
   input  logic        redirect,
   input  logic [15:0] redirect_pc,
   output logic [31:0] if_id_instr,
   output logic [15:0] if_id_pc,
   output logic        if_id_valid,
   output logic        halted,
   output logic [15:0] fetch_count
);

   import instruction_fetch_unit_pkg::*;

   fetch_state_t       state_q, state_d;
   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic [ADDR_W-1:0]  ipc_q, ipc_d;
   logic               valid_q, valid_d;
   logic [ADDR_W-1:0]  count_q, count_d;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      ipc_d   = ipc_q;
      valid_d = valid_q;
      count_d = count_q;

      if (redirect) begin
         // The word fetched this cycle is wrong-path: squash it, even if it is a HALT.
         pc_d    = redirect_pc;
         instr_d = NOP_WORD;
         valid_d = 1'b0;
         state_d = StRun;
      end else begin
         unique case (state_q)
            StRun: begin
               if (!stall) begin
                  instr_d = inst_data;
                  ipc_d   = pc_q;
                  valid_d = 1'b1;
                  count_d = count_q + 16'd1;
                  if (inst_data == HALT_WORD) begin
                     state_d = StHalted;
                  end else begin
                     pc_d = pc_q + 16'd1;
                  end
               end
            end
            StHalted: begin
               instr_d = NOP_WORD;
               valid_d = 1'b0;
            end
            default: state_d = StRun;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StRun;
         pc_q    <= RESET_PC;
         instr_q <= NOP_WORD;
         ipc_q   <= '0;
         valid_q <= 1'b0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         ipc_q   <= ipc_d;
         valid_q <= valid_d;
         count_q <= count_d;
      end
   end

   assign inst_address = pc_q;
   assign if_id_instr  = instr_q;
   assign if_id_pc     = ipc_q;
   assign if_id_valid  = valid_q;
   assign halted       = (state_q == StHalted);
   assign fetch_count  = count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Testbench for instruction_fetch_unit: directed scenarios plus randomized stall/redirect/reset
// traffic checked against a behavioural model of the fetch rules.
module tb_instruction_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] inst_address;
   logic [31:0] inst_data;
   logic        stall;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic [31:0] if_id_instr;
   logic [15:0] if_id_pc;
   logic        if_id_valid;
   logic        halted;
   logic [15:0] fetch_count;

   int n_pass  = 0;
   int n_total = 0;

   // Behavioural model of the fetch stage.
   logic [15:0] m_pc;
   bit          m_halted;
   logic [31:0] m_instr;
   logic [15:0] m_ipc;
   bit          m_valid;
   logic [15:0] m_count;

   instruction_fetch_unit dut (
      .clk         (clk),
      .rst         (rst),
      .inst_address(inst_address),
      .inst_data   (inst_data),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .if_id_instr (if_id_instr),
      .if_id_pc    (if_id_pc),
      .if_id_valid (if_id_valid),
      .halted      (halted),
      .fetch_count (fetch_count)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [15:0] addr);
      if (addr == 16'd5) return 32'hE000_0000;
      return {16'hC0DE, addr};
   endfunction

   // Stub instruction memory.
   assign inst_data = mem_word(inst_address);

   // Advance one clock edge, updating the model from the inputs held across that edge.
   task automatic step();
      logic [31:0] w;
      @(posedge clk);
      w = mem_word(m_pc);
      if (rst) begin
         m_pc = 16'h0000; m_halted = 0; m_instr = 32'h0; m_ipc = 16'h0; m_valid = 0;
         m_count = 16'h0;
      end else if (redirect) begin
         m_pc = redirect_pc; m_instr = 32'h0; m_valid = 0; m_halted = 0;
      end else if (m_halted) begin
         m_instr = 32'h0; m_valid = 0;
      end else if (!stall) begin
         m_instr = w; m_ipc = m_pc; m_valid = 1; m_count = m_count + 16'd1;
         if (w == 32'hE000_0000) m_halted = 1;
         else m_pc = m_pc + 16'd1;
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1; stall = 0; redirect = 0; redirect_pc = 16'h0;
      step(); step();
      n_total++; if (inst_address !== 16'h0000) $display("FAIL reset_addr got %h want 0000", inst_address); else n_pass++;
      n_total++; if (if_id_instr !== 32'h0) $display("FAIL reset_instr got %h want 00000000", if_id_instr); else n_pass++;
      n_total++; if (if_id_valid !== 1'b0 || halted !== 1'b0) $display("FAIL reset_flags got v=%b h=%b want 0 0", if_id_valid, halted); else n_pass++;
      n_total++; if (fetch_count !== 16'h0 || if_id_pc !== 16'h0) $display("FAIL reset_cnt got c=%h p=%h want 0 0", fetch_count, if_id_pc); else n_pass++;
   endtask

   task automatic test_fetch();
      rst = 0;
      step();
      n_total++; if (if_id_instr !== 32'hC0DE0000 || if_id_pc !== 16'h0 || if_id_valid !== 1'b1) $display("FAIL fetch0 got %h@%h v=%b want c0de0000@0000 v=1", if_id_instr, if_id_pc, if_id_valid); else n_pass++;
      n_total++; if (inst_address !== 16'h1) $display("FAIL fetch_addr1 got %h want 0001", inst_address); else n_pass++;
      step();
      n_total++; if (if_id_instr !== 32'hC0DE0001 || if_id_pc !== 16'h1) $display("FAIL fetch1 got %h@%h want c0de0001@0001", if_id_instr, if_id_pc); else n_pass++;
      n_total++; if (fetch_count !== 16'd2 || inst_address !== 16'h2) $display("FAIL fetch_cnt2 got c=%0d a=%h want 2 0002", fetch_count, inst_address); else n_pass++;
      step();
   endtask

   task automatic test_stall();
      stall = 1;
      for (int i = 0; i < 3; i++) begin
         step();
         n_total++; if (inst_address !== 16'h3 || if_id_instr !== 32'hC0DE0002 || fetch_count !== 16'd3) $display("FAIL stall_hold%0d got a=%h i=%h c=%0d want 0003 c0de0002 3", i, inst_address, if_id_instr, fetch_count); else n_pass++;
      end
      stall = 0;
      step();
      n_total++; if (if_id_instr !== 32'hC0DE0003 || inst_address !== 16'h4) $display("FAIL stall_release got i=%h a=%h want c0de0003 0004", if_id_instr, inst_address); else n_pass++;
   endtask

   task automatic test_redirect();
      stall = 1; redirect = 1; redirect_pc = 16'h0040;
      step();
      stall = 0; redirect = 0;
      n_total++; if (inst_address !== 16'h0040 || if_id_valid !== 1'b0 || if_id_instr !== 32'h0) $display("FAIL redir_squash got a=%h v=%b i=%h want 0040 0 00000000", inst_address, if_id_valid, if_id_instr); else n_pass++;
      n_total++; if (fetch_count !== 16'd4) $display("FAIL redir_count got %0d want 4", fetch_count); else n_pass++;
      step();
      n_total++; if (if_id_instr !== 32'hC0DE0040 || if_id_pc !== 16'h0040) $display("FAIL redir_target got %h@%h want c0de0040@0040", if_id_instr, if_id_pc); else n_pass++;
   endtask

   task automatic test_halt();
      redirect = 1; redirect_pc = 16'h0005;
      step();
      redirect = 0;
      step();
      n_total++; if (if_id_instr !== 32'hE0000000 || if_id_valid !== 1'b1 || halted !== 1'b1) $display("FAIL halt_capture got i=%h v=%b h=%b want e0000000 1 1", if_id_instr, if_id_valid, halted); else n_pass++;
      step();
      n_total++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || inst_address !== 16'h5 || halted !== 1'b1) $display("FAIL halt_hold got v=%b i=%h a=%h h=%b want 0 0 0005 1", if_id_valid, if_id_instr, inst_address, halted); else n_pass++;
      stall = 1;
      step();
      stall = 0;
      n_total++; if (if_id_valid !== 1'b0 || inst_address !== 16'h5 || halted !== 1'b1 || fetch_count !== 16'd6) $display("FAIL halt_stall got v=%b a=%h h=%b c=%0d want 0 0005 1 6", if_id_valid, inst_address, halted, fetch_count); else n_pass++;
      redirect = 1; redirect_pc = 16'h0010;
      step();
      redirect = 0;
      n_total++; if (halted !== 1'b0 || inst_address !== 16'h0010) $display("FAIL halt_exit got h=%b a=%h want 0 0010", halted, inst_address); else n_pass++;
      step();
      n_total++; if (if_id_instr !== 32'hC0DE0010 || if_id_valid !== 1'b1) $display("FAIL halt_resume got %h v=%b want c0de0010 1", if_id_instr, if_id_valid); else n_pass++;
      // HALT word present during a redirect cycle must not halt.
      redirect = 1; redirect_pc = 16'h0005;
      step();
      redirect_pc = 16'h0020;
      step();
      redirect = 0;
      n_total++; if (halted !== 1'b0 || inst_address !== 16'h0020 || if_id_valid !== 1'b0) $display("FAIL halt_squashed got h=%b a=%h v=%b want 0 0020 0", halted, inst_address, if_id_valid); else n_pass++;
   endtask

   task automatic test_wrap();
      redirect = 1; redirect_pc = 16'hFFFF;
      step();
      redirect = 0;
      step();
      n_total++; if (if_id_pc !== 16'hFFFF || if_id_instr !== 32'hC0DEFFFF || inst_address !== 16'h0000) $display("FAIL wrap_last got p=%h i=%h a=%h want ffff c0deffff 0000", if_id_pc, if_id_instr, inst_address); else n_pass++;
      step();
      n_total++; if (if_id_pc !== 16'h0000 || if_id_instr !== 32'hC0DE0000) $display("FAIL wrap_first got p=%h i=%h want 0000 c0de0000", if_id_pc, if_id_instr); else n_pass++;
   endtask

   task automatic test_reset_mid();
      redirect = 1; redirect_pc = 16'h0005;
      step();
      redirect = 0;
      step(); step();
      rst = 1;
      step();
      rst = 0;
      n_total++; if (halted !== 1'b0 || inst_address !== 16'h0 || if_id_valid !== 1'b0 || fetch_count !== 16'h0 || if_id_instr !== 32'h0 || if_id_pc !== 16'h0) $display("FAIL rst_halted got h=%b a=%h v=%b c=%h i=%h p=%h want all 0", halted, inst_address, if_id_valid, fetch_count, if_id_instr, if_id_pc); else n_pass++;
      step(); step(); step();
      stall = 1; rst = 1; redirect = 1; redirect_pc = 16'h1234;
      step();
      rst = 0; redirect = 0;
      n_total++; if (inst_address !== 16'h0 || if_id_valid !== 1'b0 || fetch_count !== 16'h0 || if_id_instr !== 32'h0) $display("FAIL rst_stalled got a=%h v=%b c=%h i=%h want all 0", inst_address, if_id_valid, fetch_count, if_id_instr); else n_pass++;
      stall = 0;
   endtask

   task automatic test_random();
      int bad = 0;
      for (int i = 0; i < 400; i++) begin
         rst      = ($urandom_range(0, 99) < 2);
         stall    = ($urandom_range(0, 99) < 30);
         redirect = ($urandom_range(0, 99) < 12);
         case ($urandom_range(0, 3))
            0: redirect_pc = 16'($urandom_range(0, 7));
            1: redirect_pc = 16'hFFFE;
            default: redirect_pc = 16'($urandom);
         endcase
         step();
         n_total++;
         if (inst_address !== m_pc || if_id_instr !== m_instr || if_id_pc !== m_ipc ||
             if_id_valid !== m_valid || halted !== m_halted || fetch_count !== m_count) begin
            bad++;
            if (bad <= 5)
               $display("FAIL random%0d got a=%h i=%h p=%h v=%b h=%b c=%h want a=%h i=%h p=%h v=%b h=%b c=%h",
                        i, inst_address, if_id_instr, if_id_pc, if_id_valid, halted, fetch_count,
                        m_pc, m_instr, m_ipc, m_valid, m_halted, m_count);
         end else n_pass++;
      end
      rst = 0; stall = 0; redirect = 0;
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_stall();
      test_redirect();
      test_halt();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
